// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1:4 stream demultiplexer.
package demux_pkg;

    localparam int unsigned N_LANES = 4;
    localparam int unsigned SEL_W   = 2;

    // Bit offset of lane i inside a packed N_LANES*w bus.
    function automatic int unsigned lane_slice(input int unsigned i, input int unsigned w);
        return i * w;
    endfunction

endpackage

// File: rtl/demux_lane_buf.sv
// One-entry output buffer for a single demux lane.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : load push_data this cycle (caller guarantees the slot is free or popping)
//   push_data  : payload to load
//   pop_ready  : downstream ready for this lane
//   valid      : lane holds a beat
//   data       : lane payload, held after pop until the next push
module demux_lane_buf #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // Push wins over pop so a simultaneous push/pop keeps the lane full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= push_data;
        end else if (valid && pop_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid / in_ready / in_data : input stream (in_ready is combinational)
//   in_sel    : explicit target lane, used when auto_rr=0
//   auto_rr   : 1 selects the internal round-robin counter as target
//   out_valid / out_ready / out_data : four output lanes, lane i at out_data[i*W +: W]
//   rr_lane   : current round-robin counter value
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 auto_rr,
    output logic [N_LANES-1:0]   out_valid,
    input  logic [N_LANES-1:0]   out_ready,
    output logic [N_LANES*W-1:0] out_data,
    output logic [SEL_W-1:0]     rr_lane
);

    logic [SEL_W-1:0] tgt_c;
    logic             acc_c;

    // Target decode and acceptance; readiness depends only on the target lane.
    always_comb begin
        tgt_c    = auto_rr ? rr_lane : in_sel;
        in_ready = ~out_valid[tgt_c] | out_ready[tgt_c];
        acc_c    = in_valid & in_ready;
    end

    // Round-robin counter: advances on accepted beats in auto mode, cleared outside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_lane <= '0;
        end else if (!auto_rr) begin
            rr_lane <= '0;
        end else if (acc_c) begin
            rr_lane <= rr_lane + SEL_W'(1);
        end
    end

    // Per-lane output buffers.
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        demux_lane_buf #(.W(W)) u_buf (
            .clk       (clk),
            .rst       (rst),
            .push      (acc_c && (tgt_c == SEL_W'(i))),
            .push_data (in_data),
            .pop_ready (out_ready[i]),
            .valid     (out_valid[i]),
            .data      (out_data[lane_slice(i, W) +: W])
        );
    end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: directed scenarios plus random traffic
// compared against a lane-array reference model.
module tb_demux_1_4_stream;

    localparam int unsigned W = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic          auto_rr;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*W-1:0] out_data;
    logic [1:0]    rr_lane;

    demux_1_4_stream #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .auto_rr   (auto_rr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_lane   (rr_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one slot per lane plus a lane counter.
    logic         m_full [4];
    logic [W-1:0] m_data [4];
    int unsigned  m_rr;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_tgt();
        return auto_rr ? m_rr : int'(in_sel);
    endfunction

    function automatic logic model_ready();
        int unsigned t;
        t = model_tgt();
        return !m_full[t] || out_ready[t];
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_full[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
        end
        m_rr = 0;
    endtask

    // Compare every output against the model.
    task automatic compare_all(input string tag);
        logic [W-1:0] lane;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(model_valid()));
        check({tag, ".rr_lane"}, 32'(rr_lane), m_rr);
        for (int i = 0; i < 4; i++) begin
            lane = out_data[i*W +: W];
            check($sformatf("%s.lane%0d", tag, i), 32'(lane), 32'(m_data[i]));
        end
    endtask

    // Apply inputs mid-cycle, let combinational paths settle, then check.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                         input logic a, input logic [3:0] r, input string tag);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        auto_rr   = a;
        out_ready = r;
        #1;
        compare_all(tag);
    endtask

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic tick();
        int unsigned t;
        logic acc;
        t   = model_tgt();
        acc = in_valid && model_ready();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && t == i) begin
                    m_full[i] = 1'b1;
                    m_data[i] = in_data;
                end else if (m_full[i] && out_ready[i]) begin
                    m_full[i] = 1'b0;
                end
            end
            if (!auto_rr) m_rr = 0;
            else if (acc) m_rr = (m_rr + 1) % 4;
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        auto_rr   = 1'b0;
        out_ready = 4'h0;
        model_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 4'h0, "reset");
        check("reset.valid_const", 32'(out_valid), 32'h0);
        rst = 1'b0;
        tick();

        // Reset mid-traffic: fill lanes 0 and 2, then assert rst between edges.
        drive(1, 4'h5, 0, 0, 4'h0, "fill0");
        tick();
        drive(1, 4'h6, 2, 0, 4'h0, "fill2");
        tick();
        drive(0, 0, 0, 0, 4'h0, "filled");
        check("filled.valid_const", 32'(out_valid), 32'h5);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst.valid", 32'(out_valid), 32'h0);
        check("async_rst.data", 32'(out_data), 32'h0);
        check("async_rst.rr", 32'(rr_lane), 32'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 4'hF, "post_rst");
        tick();
        drive(0, 0, 0, 0, 4'hF, "post_rst2");

        // Explicit select, all lanes ready.
        drive(1, 4'hA, 2, 0, 4'hF, "sel_a");
        check("sel_a.ready_const", 32'(in_ready), 32'h1);
        tick();
        drive(1, 4'h5, 0, 0, 4'hF, "sel_b");
        check("sel_b.lane2_const", 32'(out_data[2*W +: W]), 32'hA);
        tick();
        drive(0, 0, 0, 0, 4'hF, "sel_done");
        check("sel_done.lane0_const", 32'(out_data[0 +: W]), 32'h5);
        tick();

        // Back-pressure on lane 1.
        drive(1, 4'h3, 1, 0, 4'b1101, "bp_1");
        tick();
        drive(1, 4'h7, 1, 0, 4'b1101, "bp_2");
        check("bp_2.stall_const", 32'(in_ready), 32'h0);
        tick();
        drive(1, 4'h7, 1, 0, 4'hF, "bp_3");
        check("bp_3.lane1_const", 32'(out_data[W +: W]), 32'h3);
        tick();
        drive(1, 4'h9, 3, 0, 4'hF, "bp_4");
        check("bp_4.lane1_const", 32'(out_data[W +: W]), 32'h7);
        tick();
        drive(0, 0, 0, 0, 4'hF, "bp_5");
        check("bp_5.lane3_const", 32'(out_data[3*W +: W]), 32'h9);
        tick();

        // Round-robin deserialise of 1..5.
        for (int k = 1; k <= 5; k++) begin
            drive(1, W'(k), 0, 1, 4'hF, $sformatf("rr_beat%0d", k));
            tick();
        end
        drive(0, 0, 0, 1, 4'hF, "rr_done");
        check("rr_done.rr_const", 32'(rr_lane), 32'h1);
        check("rr_done.lane0_const", 32'(out_data[0 +: W]), 32'h5);

        // Round-robin stall with lane 2 held full.
        drive(1, 4'h8, 0, 1, 4'b1011, "rrs_l1");
        tick();
        drive(1, 4'hB, 0, 1, 4'b1011, "rrs_l2");
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, W'(k), 0, 1, 4'b1011, $sformatf("rrs_fill%0d", k));
            tick();
        end
        drive(1, 4'hC, 0, 1, 4'b1011, "rrs_stall");
        check("rrs_stall.ready_const", 32'(in_ready), 32'h0);
        check("rrs_stall.rr_const", 32'(rr_lane), 32'h2);
        tick();
        drive(1, 4'hC, 0, 1, 4'hF, "rrs_release");
        check("rrs_release.rr_const", 32'(rr_lane), 32'h2);
        tick();
        drive(0, 0, 0, 1, 4'hF, "rrs_done");
        check("rrs_done.lane2_const", 32'(out_data[2*W +: W]), 32'hC);
        check("rrs_done.rr_const", 32'(rr_lane), 32'h3);
        tick();

        // Mode switch clears the counter.
        drive(0, 0, 0, 0, 4'hF, "mode_idle");
        tick();
        drive(1, 4'hE, 0, 1, 4'hF, "mode_beat");
        check("mode_beat.rr_const", 32'(rr_lane), 32'h0);
        tick();
        drive(0, 0, 0, 1, 4'hF, "mode_done");
        check("mode_done.lane0_const", 32'(out_data[0 +: W]), 32'hE);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 3) != 0), W'($urandom), 2'($urandom),
                  ($urandom_range(0, 7) < 5), 4'($urandom), "rand");
            tick();
        end
        drive(0, 0, 0, 0, 4'hF, "final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
